// File: rtl/psw_status_reg_pkg.sv
// Shared definitions for the X-Makina PSW block: bit positions, FSM states
// and the standard flag-update masks used by the control unit.
package xm_psw_pkg;

  // PSW bit positions
  localparam int PSW_C        = 0;
  localparam int PSW_Z        = 1;
  localparam int PSW_N        = 2;
  localparam int PSW_SLP      = 3;
  localparam int PSW_V        = 4;
  localparam int PSW_PRIO_LSB = 5;
  localparam int PSW_PRIO_MSB = 7;
  localparam int PSW_PRIO_W   = PSW_PRIO_MSB - PSW_PRIO_LSB + 1;

  // Flag mask ordering is {V,N,Z,C}
  localparam logic [3:0] FLAGS_LOGIC = 4'b0110;
  localparam logic [3:0] FLAGS_ARITH = 4'b1111;

  // Save/restore sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    DONE    = 2'd3
  } psw_state_t;

endpackage

// File: rtl/psw_status_reg_if.sv
// Four-phase save/restore handshake between the exception sequencer
// (master) and the PSW register (slave).
interface psw_status_reg_if;
  import xm_psw_pkg::*;

  logic                  push_req;
  logic [PSW_PRIO_W-1:0] push_prio;
  logic                  pop_req;
  logic                  ack;
  logic                  err;

  modport master (output push_req, push_prio, pop_req, input ack, err);
  modport slave  (input push_req, push_prio, pop_req, output ack, err);

endinterface

// File: rtl/psw_status_reg_shadow_stack.sv
// Register-array LIFO holding saved PSW values. The stack pointer counts
// 0..STACK_DEPTH and never wraps; push when full and pop when empty are
// ignored so the caller can report them as errors.
module psw_shadow_stack #(
  parameter int WORD_SIZE   = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [WORD_SIZE-1:0] i_wdata,
  output logic [WORD_SIZE-1:0] o_top,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam int IW  = $clog2(STACK_DEPTH);
  localparam int SPW = IW + 1;

  logic [WORD_SIZE-1:0] r_mem [STACK_DEPTH];
  logic [SPW-1:0]       r_sp;
  logic [IW-1:0]        w_wr_idx;
  logic [IW-1:0]        w_rd_idx;

  assign w_wr_idx = r_sp[IW-1:0];
  assign w_rd_idx = IW'(r_sp - SPW'(1));
  assign o_full   = (r_sp == SPW'(STACK_DEPTH));
  assign o_empty  = (r_sp == SPW'(0));
  assign o_top    = r_mem[w_rd_idx];

  // Stack storage and pointer; reset clears every entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= SPW'(0);
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_mem[i] <= {WORD_SIZE{1'b0}};
      end
    end else if (i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_wdata;
      r_sp            <= r_sp + SPW'(1);
    end else if (i_pop && !o_empty) begin
      r_sp <= r_sp - SPW'(1);
    end else begin
      r_sp <= r_sp;
    end
  end

endmodule

// File: rtl/psw_status_reg.sv
// Processor status word: derives C/Z/N/V from ALU results, accepts explicit
// PSW loads, and saves/restores the PSW on a shadow stack under a four-phase
// req/ack handshake driven by the exception sequencer.
module psw_status_reg
  import xm_psw_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_SIZE-1:0] alu_result,
  input  logic                 alu_carry,
  input  logic                 alu_ovf,
  input  logic                 byte_op,
  input  logic                 flag_we,
  input  logic [3:0]           flag_mask,
  input  logic                 psw_wr_en,
  input  logic [WORD_SIZE-1:0] psw_wr_data,
  psw_status_reg_if.slave      hs,
  output logic [WORD_SIZE-1:0] psw,
  output logic                 flag_c,
  output logic                 flag_z,
  output logic                 flag_n,
  output logic                 flag_v,
  output logic                 busy
);

  // Only bits [7:0] are implemented; the rest read as zero
  localparam logic [WORD_SIZE-1:0] W_IMPL = {{(WORD_SIZE-8){1'b0}}, 8'hFF};

  psw_state_t           r_state;
  logic                 r_ack;
  logic                 r_err;
  logic                 r_busy;
  logic [WORD_SIZE-1:0] r_psw;

  logic [WORD_SIZE-1:0] w_flag_psw;
  logic [WORD_SIZE-1:0] w_psw_upd;
  logic [WORD_SIZE-1:0] w_psw_nxt;
  logic [WORD_SIZE-1:0] w_stack_top;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_n;
  logic                 w_z;

  assign w_n    = byte_op ? alu_result[7] : alu_result[WORD_SIZE-1];
  assign w_z    = byte_op ? (alu_result[7:0] == 8'h00)
                          : (alu_result == {WORD_SIZE{1'b0}});
  // Stack moves only on a real commit, never on full/empty
  assign w_push = (r_state == SAVE) && !w_full;
  assign w_pop  = (r_state == RESTORE) && !w_empty;

  psw_shadow_stack #(
    .WORD_SIZE  (WORD_SIZE),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_wdata(r_psw),
    .o_top  (w_stack_top),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  // Masked flag merge; SLP and PRIO pass through untouched
  always_comb begin
    w_flag_psw        = r_psw;
    w_flag_psw[PSW_C] = flag_mask[0] ? alu_carry : r_psw[PSW_C];
    w_flag_psw[PSW_Z] = flag_mask[1] ? w_z       : r_psw[PSW_Z];
    w_flag_psw[PSW_N] = flag_mask[2] ? w_n       : r_psw[PSW_N];
    w_flag_psw[PSW_V] = flag_mask[3] ? alu_ovf   : r_psw[PSW_V];
  end

  // Next PSW: restore beats explicit load beats flag update; push_prio
  // overrides PRIO of whatever the live update produced
  always_comb begin
    w_psw_upd = r_psw;
    if (psw_wr_en) begin
      w_psw_upd = psw_wr_data & W_IMPL;
    end else if (flag_we) begin
      w_psw_upd = w_flag_psw;
    end else begin
      w_psw_upd = r_psw;
    end
    w_psw_nxt = w_psw_upd;
    if (w_pop) begin
      w_psw_nxt = w_stack_top;
    end else if (w_push) begin
      w_psw_nxt[PSW_PRIO_MSB:PSW_PRIO_LSB] = hs.push_prio;
    end else begin
      w_psw_nxt = w_psw_upd;
    end
  end

  // Live PSW register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psw <= {WORD_SIZE{1'b0}};
    end else begin
      r_psw <= w_psw_nxt;
    end
  end

  // Save/restore handshake sequencer with registered ack/err/busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (hs.push_req && hs.pop_req) begin
            r_state <= DONE;
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
            r_busy  <= 1'b1;
          end else if (hs.push_req) begin
            r_state <= SAVE;
            r_busy  <= 1'b1;
          end else if (hs.pop_req) begin
            r_state <= RESTORE;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        SAVE: begin
          r_state <= DONE;
          r_ack   <= 1'b1;
          r_err   <= w_full;
        end
        RESTORE: begin
          r_state <= DONE;
          r_ack   <= 1'b1;
          r_err   <= w_empty;
        end
        DONE: begin
          if (!hs.push_req && !hs.pop_req) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign psw    = r_psw;
  assign flag_c = r_psw[PSW_C];
  assign flag_z = r_psw[PSW_Z];
  assign flag_n = r_psw[PSW_N];
  assign flag_v = r_psw[PSW_V];
  assign busy   = r_busy;
  assign hs.ack = r_ack;
  assign hs.err = r_err;

endmodule

// File: tb/tb_psw_status_reg.sv
// Scoreboard bench for psw_status_reg: stimulus queues expected PSW values
// and handshake responses; monitor threads compare when the DUT presents them.
module tb_psw_status_reg;
  import xm_psw_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        alu_ovf;
  logic        byte_op;
  logic        flag_we;
  logic [3:0]  flag_mask;
  logic        psw_wr_en;
  logic [15:0] psw_wr_data;
  logic [15:0] psw;
  logic        flag_c, flag_z, flag_n, flag_v;
  logic        busy;

  psw_status_reg_if hs();

  psw_status_reg #(.WORD_SIZE(16), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_ovf(alu_ovf), .byte_op(byte_op), .flag_we(flag_we), .flag_mask(flag_mask),
    .psw_wr_en(psw_wr_en), .psw_wr_data(psw_wr_data), .hs(hs), .psw(psw),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .busy(busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] ack_q [$];  // {err, psw} expected at each ack
  logic [15:0] psw_q [$];  // psw expected one edge after each update cycle
  logic        ack_prev = 1'b0;
  logic        wr_prev  = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Clock-side monitor: ack rising edge and post-update PSW
  task automatic mon_clk();
    logic [16:0] ea;
    logic [15:0] ep;
    if (hs.ack === 1'b1 && ack_prev !== 1'b1) begin
      checks++;
      if (ack_q.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected got err=%0b psw=%h required no ack", hs.err, psw);
      end else begin
        ea = ack_q.pop_front();
        if ({hs.err, psw, busy} !== {ea, 1'b1}) begin
          errors++;
          $display("FAIL ack_resp got err=%0b psw=%h busy=%0b required err=%0b psw=%h busy=1",
                   hs.err, psw, busy, ea[16], ea[15:0]);
        end
      end
    end
    ack_prev = hs.ack;
    if (wr_prev && psw_q.size() != 0) begin
      ep = psw_q.pop_front();
      checks++;
      if (psw !== ep || {flag_v, flag_n, flag_z, flag_c} !== {ep[4], ep[2], ep[1], ep[0]}) begin
        errors++;
        $display("FAIL psw_update got psw=%h vnzc=%b%b%b%b required psw=%h",
                 psw, flag_v, flag_n, flag_z, flag_c, ep);
      end
    end
    wr_prev = flag_we | psw_wr_en;
  endtask

  // Reset-side monitor: state must clear without waiting for a clock
  task automatic mon_rst();
    checks++;
    if ({psw, hs.ack, hs.err, busy} !== 19'd0) begin
      errors++;
      $display("FAIL async_reset got psw=%h ack=%0b err=%0b busy=%0b required all 0",
               psw, hs.ack, hs.err, busy);
    end
  endtask

  task automatic upd(input logic we, input logic [3:0] mask, input logic bop,
                     input logic [15:0] res, input logic c, input logic v,
                     input logic pwe, input logic [15:0] pd, input logic [15:0] exp_psw);
    flag_we = we; flag_mask = mask; byte_op = bop; alu_result = res;
    alu_carry = c; alu_ovf = v; psw_wr_en = pwe; psw_wr_data = pd;
    psw_q.push_back(exp_psw);
    step();
    flag_we = 1'b0; psw_wr_en = 1'b0;
  endtask

  task automatic wait_ack(input logic level);
    for (int i = 0; i < 20 && hs.ack !== level; i++) @(negedge clk);
    checks++;
    if (hs.ack !== level) begin
      errors++;
      $display("FAIL ack_timeout got ack=%b required %0b within 20 cycles", hs.ack, level);
    end
  endtask

  task automatic finish_hs();
    wait_ack(1'b1);
    step();
    hs.push_req = 1'b0; hs.pop_req = 1'b0;
    wait_ack(1'b0);
    step();
  endtask

  task automatic xact(input logic do_push, input logic do_pop, input logic [2:0] prio,
                      input logic exp_err, input logic [15:0] exp_psw);
    ack_q.push_back({exp_err, exp_psw});
    hs.push_req = do_push; hs.pop_req = do_pop; hs.push_prio = prio;
    finish_hs();
  endtask

  // Request plus a flag update landing on the SAVE/RESTORE commit edge
  task automatic xact_flag(input logic do_push, input logic do_pop, input logic [2:0] prio,
                           input logic [3:0] mask, input logic [15:0] res,
                           input logic c, input logic v, input logic [15:0] exp_psw);
    ack_q.push_back({1'b0, exp_psw});
    hs.push_req = do_push; hs.pop_req = do_pop; hs.push_prio = prio;
    step();
    upd(1'b1, mask, 1'b0, res, c, v, 1'b0, 16'h0000, exp_psw);
    finish_hs();
  endtask

  initial begin
    rst_n = 1'b1;
    alu_result = 16'h0000; alu_carry = 1'b0; alu_ovf = 1'b0; byte_op = 1'b0;
    flag_we = 1'b0; flag_mask = 4'b0000; psw_wr_en = 1'b0; psw_wr_data = 16'h0000;
    hs.push_req = 1'b0; hs.pop_req = 1'b0; hs.push_prio = 3'd0;
    fork
      forever begin @(negedge clk); mon_clk(); end
      forever begin @(negedge rst_n); #1; mon_rst(); end
    join_none
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Explicit loads and flag derivation
    upd(1'b0, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hFF11, 16'h0011);
    upd(1'b1, FLAGS_LOGIC, 1'b1, 16'hFF00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0013);
    upd(1'b1, FLAGS_ARITH, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0015);
    upd(1'b1, FLAGS_LOGIC, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0013);
    upd(1'b1, FLAGS_ARITH, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    upd(1'b0, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0005);

    // Push/pop round trip
    xact(1'b1, 1'b0, 3'd6, 1'b0, 16'h00C5);
    upd(1'b0, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    xact(1'b0, 1'b1, 3'd0, 1'b0, 16'h0005);

    // Overflow then underflow
    xact(1'b1, 1'b0, 3'd1, 1'b0, 16'h0025);
    xact(1'b1, 1'b0, 3'd2, 1'b0, 16'h0045);
    xact(1'b1, 1'b0, 3'd3, 1'b0, 16'h0065);
    xact(1'b1, 1'b0, 3'd4, 1'b0, 16'h0085);
    xact(1'b1, 1'b0, 3'd5, 1'b1, 16'h0085);
    xact(1'b0, 1'b1, 3'd0, 1'b0, 16'h0065);
    xact(1'b0, 1'b1, 3'd0, 1'b0, 16'h0045);
    xact(1'b0, 1'b1, 3'd0, 1'b0, 16'h0025);
    xact(1'b0, 1'b1, 3'd0, 1'b0, 16'h0005);
    xact(1'b0, 1'b1, 3'd0, 1'b1, 16'h0005);

    // Both requests together leave sp alone
    xact(1'b1, 1'b0, 3'd7, 1'b0, 16'h00E5);
    xact(1'b1, 1'b1, 3'd0, 1'b1, 16'h00E5);
    xact(1'b0, 1'b1, 3'd0, 1'b0, 16'h0005);

    // Same-edge flag updates during RESTORE and SAVE
    xact(1'b1, 1'b0, 3'd2, 1'b0, 16'h0045);
    xact_flag(1'b0, 1'b1, 3'd0, FLAGS_ARITH, 16'h0000, 1'b1, 1'b1, 16'h0005);
    xact_flag(1'b1, 1'b0, 3'd3, FLAGS_LOGIC, 16'h0000, 1'b0, 1'b0, 16'h0063);
    xact(1'b0, 1'b1, 3'd0, 1'b0, 16'h0005);

    // Explicit load wins over flag update
    upd(1'b1, FLAGS_ARITH, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h00FF, 16'h00FF);

    // Reset in the middle of a SAVE: nothing may be committed
    hs.push_req = 1'b1; hs.push_prio = 3'd4;
    step();
    #2 rst_n = 1'b0;
    #5 hs.push_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    xact(1'b0, 1'b1, 3'd0, 1'b1, 16'h0000);
    xact(1'b1, 1'b0, 3'd1, 1'b0, 16'h0020);
    xact(1'b0, 1'b1, 3'd0, 1'b0, 16'h0000);

    repeat (2) step();
    checks++;
    if (ack_q.size() != 0 || psw_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got ack_q=%0d psw_q=%0d required 0 0",
               ack_q.size(), psw_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
